// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine that owns the architectural HI/LO registers.
// It runs one shift-add or restoring-divide step per cycle, then a FIX cycle applies the signs.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e             state_q;
    logic [CW-1:0]      counter_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               neg_q, rneg_q, is_mul_q;
    logic               busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_rs, div_diff;
    logic [2*WIDTH-1:0] mul_d, div_d, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        signed_op = (op_i == 3'd0) || (op_i == 3'd2);
        mag_a     = (signed_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
        mag_b     = (signed_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

        // Multiply: the multiplier sits in the low half and is consumed LSB first.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: remainder in the high half, dividend/quotient shifting through the low half.
        div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_rs - {1'b0, opnd_q};
        div_d    = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix = neg_q  ? -acc_q : acc_q;
        quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            is_mul_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i && op_i <= 3'd5) begin
                            dbz_q     <= 1'b0;
                            counter_q <= '0;
                            neg_q     <= signed_op && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                            rneg_q    <= signed_op && src_a_i[WIDTH-1];
                            case (op_i)
                                3'd4: begin
                                    hi_q   <= src_a_i;
                                    done_q <= 1'b1;
                                end
                                3'd5: begin
                                    lo_q   <= src_a_i;
                                    done_q <= 1'b1;
                                end
                                3'd0, 3'd1: begin
                                    acc_q    <= {{WIDTH{1'b0}}, mag_b};
                                    opnd_q   <= mag_a;
                                    is_mul_q <= 1'b1;
                                    busy_q   <= 1'b1;
                                    state_q  <= S_MUL;
                                end
                                default: begin
                                    // A zero divisor resolves immediately without iterating.
                                    if (src_b_i == '0) begin
                                        hi_q   <= src_a_i;
                                        lo_q   <= '1;
                                        dbz_q  <= 1'b1;
                                        done_q <= 1'b1;
                                    end else begin
                                        acc_q    <= {{WIDTH{1'b0}}, mag_a};
                                        opnd_q   <= mag_b;
                                        is_mul_q <= 1'b0;
                                        busy_q   <= 1'b1;
                                        state_q  <= S_DIV;
                                    end
                                end
                            endcase
                        end
                    end
                    S_MUL, S_DIV: begin
                        acc_q     <= (state_q == S_MUL) ? mul_d : div_d;
                        counter_q <= counter_q + 1'b1;
                        if (counter_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                    end
                    default: begin
                        if (is_mul_q) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: hand-computed HI/LO results, timing, flush and reset cases.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int overlap = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op),
        .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
        .busy_o(busy), .done_o(done), .div_by_zero_o(dbz),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && done) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a MUL/DIV op and checks busy/done timing plus the final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, b,
                          input logic [31:0] eh, el, input bit scramble, input bit inject);
        int dc0;
        dc0 = done_cnt;
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        chk({tag, "_busy_N"}, busy, 1);
        chk({tag, "_done_N"}, done, 0);
        if (scramble) begin src_a = 32'h5A5A5A5A; src_b = 32'h3; end
        for (int i = 1; i <= 32; i++) begin
            if (inject && i == 5) begin start = 1'b1; op = 3'd5; src_a = 32'hDEAD; end
            tick();
            start = 1'b0;
        end
        chk({tag, "_busy_N32"}, busy, 1);
        chk({tag, "_done_N32"}, done, 0);
        tick();
        chk({tag, "_busy_N33"}, busy, 0);
        chk({tag, "_done_N33"}, done, 1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_dbz"}, dbz, 0);
        tick();
        chk({tag, "_done_N34"}, done, 0);
        chk({tag, "_done_count"}, done_cnt - dc0, 1);
    endtask

    initial begin
        logic [31:0] ph, pl;
        int dc0;

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        #10 rst_n = 1'b1;
        tick();

        run_op("mult_neg3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 0);
        run_op("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op("divu_7_2_scr", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1, 0);

        // Divide by zero: immediate write, flag set, no busy.
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd0;
        tick();
        start = 1'b0;
        chk("dbz_done", done, 1);
        chk("dbz_flag", dbz, 1);
        chk("dbz_busy", busy, 0);
        chk("dbz_hi", hi, 32'd100);
        chk("dbz_lo", lo, 32'hFFFFFFFF);
        tick();
        chk("dbz_done_off", done, 0);

        start = 1'b1; op = 3'd5; src_a = 32'h1234;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi", hi, 32'd100);
        chk("mtlo_done", done, 1);
        chk("mtlo_busy", busy, 0);
        chk("mtlo_dbz_clr", dbz, 0);
        tick();

        start = 1'b1; op = 3'd4; src_a = 32'hCAFE0001;
        tick();
        start = 1'b0;
        chk("mthi_hi", hi, 32'hCAFE0001);
        chk("mthi_done", done, 1);
        tick();

        // Reserved op: nothing happens.
        dc0 = done_cnt;
        start = 1'b1; op = 3'd6; src_a = 32'h77;
        tick();
        start = 1'b0;
        chk("rsvd_busy", busy, 0);
        tick();
        chk("rsvd_no_done", done_cnt - dc0, 0);
        chk("rsvd_hi", hi, 32'hCAFE0001);

        // Flush mid-multiply.
        ph = hi; pl = lo; dc0 = done_cnt;
        start = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("flush_busy_pre", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        repeat (40) tick();
        chk("flush_no_done", done_cnt - dc0, 0);
        chk("flush_hi", hi, ph);
        chk("flush_lo", lo, pl);

        run_op("multu_inject", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 0, 1);

        // Async reset mid-divide, then restart.
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_dbz", dbz, 0);
        #2 rst_n = 1'b1;
        tick();
        run_op("divu_restart", 3'd3, 32'd1000, 32'd7, 32'd6, 32'd142, 0, 0);

        chk("busy_done_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
